// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle RV32 controller: FSM states, opcodes,
// ALUControl codes, datapath mux encodings and the registered control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    BAD      = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_R     = 2'd1,
    CLS_I     = 2'd2,
    CLS_B     = 2'd3
  } alu_class_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_DIV   = 4'd4;
  localparam logic [3:0] ALU_REM   = 4'd6;
  localparam logic [3:0] ALU_AND   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Moore part of the control word; fetch/branch are qualified by mem_ready/Zero outside the register.
  typedef struct packed {
    logic       pc_update;
    logic       adr_src;
    logic       mem_write;
    logic       fetch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       reg_write;
    logic       branch;
    logic       illegal;
  } ctrl_out_t;

  function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      OP_LUI:  return IMM_U;
      default: return IMM_I;
    endcase
  endfunction

  function automatic alu_class_t alu_class_of(input logic [6:0] opcode);
    case (opcode)
      OP_R:    return CLS_R;
      OP_I:    return CLS_I;
      OP_BR:   return CLS_B;
      default: return CLS_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath plus unified memory (slave).
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       RegWrite;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, illegal
  );

  modport slave (
    output opcode, funct3, funct7, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps instruction class and funct fields to ALUControl
// and flags funct combinations the core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [3:0]  alu_control,
  output logic        illegal_funct
);

  // Decode ALU operation per instruction class.
  always_comb begin
    alu_control   = ALU_ADD;
    illegal_funct = 1'b0;
    case (alu_class)
      CLS_R: begin
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: alu_control = ALU_ADD;
          {7'b0000000, 3'b010}: alu_control = ALU_SLT;
          {7'b0000000, 3'b111}: alu_control = ALU_AND;
          {7'b0100000, 3'b000}: alu_control = ALU_SUB;
          {7'b0000001, 3'b100}: alu_control = ALU_DIV;
          {7'b0000001, 3'b110}: alu_control = ALU_REM;
          default:              illegal_funct = 1'b1;
        endcase
      end
      CLS_I: begin
        case (funct3)
          3'b000:  alu_control = ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b111:  alu_control = ALU_AND;
          default: illegal_funct = 1'b1;
        endcase
      end
      CLS_B: begin
        alu_control = ALU_SUB;
        if (funct3[2:1] != 2'b00) begin
          illegal_funct = 1'b1;
        end else begin
          illegal_funct = 1'b0;
        end
      end
      default: begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM (fetch/decode/execute/writeback with mem_ready waits).
// Build option ILLEGAL_TRAP_EN: illegal instructions lock the core in BAD until reset.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  alu_class_t alu_class_s;
  logic [3:0] alu_control_s;
  logic       illegal_funct_s;
  logic       run_s;
  state_t     state_r;
  ctrl_out_t  out_r;

  assign alu_class_s = alu_class_of(bus.opcode);

  alu_decoder u_alu_decoder (
    .alu_class     (alu_class_s),
    .funct3        (bus.funct3),
    .funct7        (bus.funct7),
    .alu_control   (alu_control_s),
    .illegal_funct (illegal_funct_s)
  );

  function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                        input logic mem_ready, input logic bad_funct);
    case (s)
      FETCH:    return mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: return MEMADR;
          OP_R:         return EXECR;
          OP_I:         return EXECI;
          OP_BR:        return BRANCH;
          OP_JAL:       return JAL;
          OP_LUI:       return LUI;
          default:      return BAD;
        endcase
      end
      MEMADR:   return (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  return mem_ready ? MEMWB : MEMREAD;
      MEMWB:    return FETCH;
      MEMWRITE: return mem_ready ? FETCH : MEMWRITE;
      EXECR:    return bad_funct ? BAD : ALUWB;
      EXECI:    return bad_funct ? BAD : ALUWB;
      ALUWB:    return FETCH;
      BRANCH:   return bad_funct ? BAD : FETCH;
      JAL:      return ALUWB;
      LUI:      return ALUWB;
`ifdef ILLEGAL_TRAP_EN
      BAD:      return BAD;
`else
      BAD:      return FETCH;
`endif
      default:  return FETCH;
    endcase
  endfunction

  // funct fields come from the latched IR, so the decode made one state early still holds.
  function automatic ctrl_out_t outputs_for(input state_t s, input logic [3:0] alu_code,
                                            input logic funct_ok);
    ctrl_out_t o;
    o = '0;
    case (s)
      FETCH: begin
        o.fetch = 1'b1;  o.alu_src_a = SRCA_PC;  o.alu_src_b = SRCB_FOUR;
        o.alu_control = ALU_ADD;  o.result_src = RES_ALURESULT;
      end
      DECODE:   begin o.alu_src_a = SRCA_OLDPC; o.alu_src_b = SRCB_IMM; end
      MEMADR:   begin o.alu_src_a = SRCA_RS1;   o.alu_src_b = SRCB_IMM; end
      MEMREAD:  o.adr_src = 1'b1;
      MEMWB:    begin o.result_src = RES_DATA; o.reg_write = 1'b1; end
      MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
      EXECR: begin
        o.alu_src_a = SRCA_RS1;  o.alu_src_b = SRCB_RS2;  o.alu_control = alu_code;
      end
      EXECI: begin
        o.alu_src_a = SRCA_RS1;  o.alu_src_b = SRCB_IMM;  o.alu_control = alu_code;
      end
      ALUWB:    begin o.result_src = RES_ALUOUT; o.reg_write = 1'b1; end
      BRANCH: begin
        o.alu_src_a = SRCA_RS1;  o.alu_src_b = SRCB_RS2;  o.alu_control = ALU_SUB;
        o.result_src = RES_ALUOUT;  o.branch = funct_ok;
      end
      JAL: begin
        o.alu_src_a = SRCA_OLDPC;  o.alu_src_b = SRCB_FOUR;  o.alu_control = ALU_ADD;
        o.result_src = RES_ALUOUT;  o.pc_update = 1'b1;
      end
      LUI:      begin o.alu_src_b = SRCB_IMM; o.alu_control = ALU_PASSB; end
      BAD:      o.illegal = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  // State register and registered control word for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      out_r   <= outputs_for(FETCH, ALU_ADD, 1'b1);
    end else begin
      state_r <= next_state(state_r, bus.opcode, bus.mem_ready, illegal_funct_s);
      out_r   <= outputs_for(next_state(state_r, bus.opcode, bus.mem_ready, illegal_funct_s),
                             alu_control_s, ~illegal_funct_s);
    end
  end

  // Reset masks every output in the same cycle, so a pending store or writeback is dropped.
  assign run_s = ~reset;

  assign bus.PCWrite    = run_s & ((out_r.fetch & bus.mem_ready) | out_r.pc_update |
                                   (out_r.branch & (bus.Zero ^ bus.funct3[0])));
  assign bus.IRWrite    = run_s & out_r.fetch & bus.mem_ready;
  assign bus.AdrSrc     = run_s & out_r.adr_src;
  assign bus.MemWrite   = run_s & out_r.mem_write;
  assign bus.RegWrite   = run_s & out_r.reg_write;
  assign bus.illegal    = run_s & out_r.illegal;
  assign bus.ResultSrc  = {2{run_s}} & out_r.result_src;
  assign bus.ALUSrcA    = {2{run_s}} & out_r.alu_src_a;
  assign bus.ALUSrcB    = {2{run_s}} & out_r.alu_src_b;
  assign bus.ALUControl = {4{run_s}} & out_r.alu_control;
  assign bus.ImmSrc     = {3{run_s}} & imm_src_of(bus.opcode);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller; one vector per clock cycle.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic        mr;
    logic [18:0] exp;
    logic [18:0] mask;
  } vec_t;

  vec_t tbl[$];

  localparam logic [18:0] ALL = 19'h7FFFF;
  localparam logic [18:0] NO_ALU = 19'h7FFC3;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite,illegal}
  function automatic logic [18:0] o(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [2:0] imm,
                                    input logic [3:0] alu, input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
  endfunction

  function automatic logic [18:0] ef(input logic mr, input logic [2:0] imm);
    return o(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, imm, 4'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] ed(input logic [2:0] imm);
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] ewb(input logic [2:0] imm);
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 4'd0, 1'b1, 1'b0);
  endfunction

  task automatic v(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                   input logic [6:0] f7, input logic z, input logic mr,
                   input logic [18:0] exp, input logic [18:0] mask = ALL);
    vec_t t;
    t.rst = rst; t.op = op; t.f3 = f3; t.f7 = f7; t.z = z; t.mr = mr;
    t.exp = exp; t.mask = mask;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [18:0] act;
    @(negedge clk);
    reset = t.rst;  bus.opcode = t.op;  bus.funct3 = t.f3;  bus.funct7 = t.f7;
    bus.Zero = t.z; bus.mem_ready = t.mr;
    #1;
    act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
           bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.RegWrite, bus.illegal};
    total++;
    if ((act & t.mask) !== (t.exp & t.mask)) begin
      bad++;
      $display("FAIL vec%0d op=%b f3=%b: got %b want %b", idx, t.op, t.f3, act, t.exp);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    tbl.delete();
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, XX = 7'b1111111;
  localparam logic [6:0] F0 = 7'b0000000, F1 = 7'b0000001, F32 = 7'b0100000;

  initial begin
    bus.opcode = R; bus.funct3 = 3'b000; bus.funct7 = F0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;

    // reset with mem_ready high, then add in exactly 4 cycles
    v(1'b1, R, 3'b000, F0, 1'b0, 1'b1, 19'd0);
    v(1'b1, R, 3'b000, F0, 1'b0, 1'b1, 19'd0);
    v(1'b0, R, 3'b000, F0, 1'b0, 1'b1, ef(1'b1, 3'b000));
    v(1'b0, R, 3'b000, F0, 1'b0, 1'b1, ed(3'b000));
    v(1'b0, R, 3'b000, F0, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd0, 0, 0));
    v(1'b0, R, 3'b000, F0, 1'b0, 1'b1, ewb(3'b000));
    // div, with a fetch stall first
    v(1'b0, R, 3'b100, F1, 1'b0, 1'b0, ef(1'b0, 3'b000));
    v(1'b0, R, 3'b100, F1, 1'b0, 1'b1, ef(1'b1, 3'b000));
    v(1'b0, R, 3'b100, F1, 1'b0, 1'b1, ed(3'b000));
    v(1'b0, R, 3'b100, F1, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd4, 0, 0));
    v(1'b0, R, 3'b100, F1, 1'b0, 1'b1, ewb(3'b000));
    // sub
    v(1'b0, R, 3'b000, F32, 1'b0, 1'b1, ef(1'b1, 3'b000));
    v(1'b0, R, 3'b000, F32, 1'b0, 1'b1, ed(3'b000));
    v(1'b0, R, 3'b000, F32, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd3, 0, 0));
    v(1'b0, R, 3'b000, F32, 1'b0, 1'b1, ewb(3'b000));
    // andi
    v(1'b0, I, 3'b111, F0, 1'b0, 1'b1, ef(1'b1, 3'b000));
    v(1'b0, I, 3'b111, F0, 1'b0, 1'b1, ed(3'b000));
    v(1'b0, I, 3'b111, F0, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd7, 0, 0));
    v(1'b0, I, 3'b111, F0, 1'b0, 1'b1, ewb(3'b000));
    // lw with 3 wait cycles: 8 cycles total
    v(1'b0, LW, 3'b010, F0, 1'b0, 1'b1, ef(1'b1, 3'b000));
    v(1'b0, LW, 3'b010, F0, 1'b0, 1'b0, ed(3'b000));
    v(1'b0, LW, 3'b010, F0, 1'b0, 1'b0, o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 0, 0));
    for (int k = 0; k < 4; k++)
      v(1'b0, LW, 3'b010, F0, 1'b0, (k == 3), o(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 0));
    v(1'b0, LW, 3'b010, F0, 1'b0, 1'b0, o(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0, 1, 0));
    // sw, strobe held across a wait
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b1, ef(1'b1, 3'b001));
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b1, ed(3'b001));
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0, 0));
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b0, o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0));
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b1, o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0));
    // branches: {f3, Zero, expected PCWrite}
    for (int k = 0; k < 4; k++) begin
      logic [2:0] f3;
      logic zz, tk;
      f3 = (k < 2) ? 3'b000 : 3'b001;
      zz = k[0];
      tk = (k == 1) || (k == 2);
      v(1'b0, BR, f3, F0, zz, 1'b1, ef(1'b1, 3'b010));
      v(1'b0, BR, f3, F0, zz, 1'b1, ed(3'b010));
      v(1'b0, BR, f3, F0, zz, 1'b1, o(tk, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 4'd3, 0, 0));
    end
    // jal
    v(1'b0, JL, 3'b000, F0, 1'b0, 1'b1, ef(1'b1, 3'b011));
    v(1'b0, JL, 3'b000, F0, 1'b0, 1'b1, ed(3'b011));
    v(1'b0, JL, 3'b000, F0, 1'b0, 1'b1, o(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 4'd0, 0, 0));
    v(1'b0, JL, 3'b000, F0, 1'b0, 1'b1, ewb(3'b011));
    // lui
    v(1'b0, LU, 3'b000, F0, 1'b0, 1'b1, ef(1'b1, 3'b100));
    v(1'b0, LU, 3'b000, F0, 1'b0, 1'b1, ed(3'b100));
    v(1'b0, LU, 3'b000, F0, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b100, 4'd8, 0, 0));
    v(1'b0, LU, 3'b000, F0, 1'b0, 1'b1, ewb(3'b100));
    // sw interrupted by reset while the strobe waits on memory
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b1, ef(1'b1, 3'b001));
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b1, ed(3'b001));
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 0, 0));
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b0, o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd0, 0, 0));
    v(1'b1, SW, 3'b010, F0, 1'b0, 1'b0, 19'd0);
    v(1'b0, SW, 3'b010, F0, 1'b0, 1'b0, ef(1'b0, 3'b001));
    run_table();

    // illegal opcode
    v(1'b0, XX, 3'b000, F0, 1'b1, 1'b1, ef(1'b1, 3'b000));
    v(1'b0, XX, 3'b000, F0, 1'b1, 1'b1, ed(3'b000));
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 12; k++)
      v(1'b0, XX, 3'b000, F0, 1'b1, k[0], o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 1));
    v(1'b1, R, 3'b000, F0, 1'b0, 1'b1, 19'd0);
    v(1'b0, R, 3'b000, F0, 1'b0, 1'b1, ef(1'b1, 3'b000));
`else
    v(1'b0, XX, 3'b000, F0, 1'b1, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 1));
    v(1'b0, XX, 3'b000, F0, 1'b1, 1'b0, ef(1'b0, 3'b000));
    // unsupported R-type funct: EXECR then a one-cycle BAD, no writeback
    v(1'b0, R, 3'b111, F32, 1'b0, 1'b1, ef(1'b1, 3'b000));
    v(1'b0, R, 3'b111, F32, 1'b0, 1'b1, ed(3'b000));
    v(1'b0, R, 3'b111, F32, 1'b0, 1'b1,
      o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd0, 0, 0), NO_ALU);
    v(1'b0, R, 3'b111, F32, 1'b0, 1'b1, o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 0, 1));
    v(1'b0, R, 3'b111, F32, 1'b0, 1'b1, ef(1'b1, 3'b000));
`endif
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
